rom_arbiter: RTL

- Shares one instruction ROM port (10-bit word address, 32-bit data, address registered on rising Clock, data valid the cycle after the address is presented) between two requesters.
- Port 0 is instruction fetch; port 1 is the data/constant-load path.
- Arbitrates every cycle, drives the ROM address, and steers the returned word back to the owning requester with a 1-cycle valid strobe.
- Arbitration is round-robin with a burst limit, or fixed priority with a starvation guard.

---
 rtl/rom_arbiter_if.sv | 35 +++
 rtl/rom_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/rom_arbiter_if.sv
// ROM arbiter bus: two requester ports plus the shared ROM port.
// slave = arbiter side, master = requesters and ROM side.
interface rom_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  Req0;
  logic [ADDR_WIDTH-1:0] Addr0;
  logic                  Gnt0;
  logic                  Valid0;
  logic [DATA_WIDTH-1:0] Data0;
  logic                  Req1;
  logic [ADDR_WIDTH-1:0] Addr1;
  logic                  Gnt1;
  logic                  Valid1;
  logic [DATA_WIDTH-1:0] Data1;
  logic [ADDR_WIDTH-1:0] RomAddress;
  logic [DATA_WIDTH-1:0] RomReadData;

  modport slave (
    input  Req0, Addr0, Req1, Addr1,
    input  RomReadData,
    output Gnt0, Valid0, Data0,
    output Gnt1, Valid1, Data1,
    output RomAddress
  );

  modport master (
    output Req0, Addr0, Req1, Addr1,
    output RomReadData,
    input  Gnt0, Valid0, Data0,
    input  Gnt1, Valid1, Data1,
    input  RomAddress
  );
endinterface

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a registered-address instruction ROM.
// Round-robin with burst limit, or fixed priority with starvation guard.
module rom_arbiter #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int PRIORITY_MODE = 0,
  parameter int MAX_BURST     = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input logic          Clock,
  input logic          Reset,
  rom_arbiter_if.slave bus
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(STARVE_LIMIT);

  logic                  last_owner;
  logic [BW-1:0]         burst_cnt;
  logic [WW-1:0]         wait1;
  logic                  pend_valid;
  logic                  pend_owner;
  logic [ADDR_WIDTH-1:0] addr_hold;

  logic                  last_owner_nx;
  logic [BW-1:0]         burst_cnt_nx;
  logic [WW-1:0]         wait1_nx;

  logic                  both;
  logic                  any_req;
  logic                  win1;
  logic                  gnt_any;
  logic                  gnt0;
  logic                  gnt1;
  logic                  valid0;
  logic                  valid1;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] rdata;

  // Winner select; a lone requester always wins.
  always_comb begin
    both    = bus.Req0 & bus.Req1;
    any_req = bus.Req0 | bus.Req1;
    win1    = bus.Req1;
    if (both) begin
      if (PRIORITY_MODE == 0) begin
        win1 = (burst_cnt < BURST_MAX) ? last_owner : ~last_owner;
      end else begin
        win1 = (wait1 >= WAIT_MAX);
      end
    end
    gnt_any = any_req & Reset;
    gnt0    = gnt_any & ~win1;
    gnt1    = gnt_any & win1;
  end

  always_comb begin
    last_owner_nx = last_owner;
    burst_cnt_nx  = burst_cnt;
    if (gnt_any) begin
      if (win1 == last_owner) begin
        if (burst_cnt < BURST_MAX) begin
          burst_cnt_nx = burst_cnt + 1'b1;
        end
      end else begin
        last_owner_nx = win1;
        burst_cnt_nx  = BW'(1);
      end
    end
  end

  always_comb begin
    wait1_nx = '0;
    if (bus.Req1 && !gnt1) begin
      wait1_nx = (wait1 < WAIT_MAX) ? wait1 + 1'b1 : wait1;
    end
  end

  always_comb begin
    win_addr = addr_hold;
    unique case (1'b1)
      gnt1:    win_addr = bus.Addr1;
      gnt0:    win_addr = bus.Addr0;
      default: win_addr = addr_hold;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      last_owner <= 1'b1;
      burst_cnt  <= BURST_MAX;
      wait1      <= '0;
      pend_valid <= 1'b0;
      pend_owner <= 1'b0;
      addr_hold  <= '0;
    end else begin
      last_owner <= last_owner_nx;
      burst_cnt  <= burst_cnt_nx;
      wait1      <= wait1_nx;
      pend_valid <= gnt_any;
      if (gnt_any) begin
        pend_owner <= win1;
        addr_hold  <= win_addr;
      end
    end
  end

  // Response gated by Reset so a grant just before reset never returns.
  always_comb begin
    rdata  = bus.RomReadData;
    valid0 = pend_valid & ~pend_owner & Reset;
    valid1 = pend_valid & pend_owner & Reset;
  end

  always_comb begin
    bus.Gnt0       = gnt0;
    bus.Gnt1       = gnt1;
    bus.RomAddress = win_addr;
    bus.Valid0     = valid0;
    bus.Valid1     = valid1;
    bus.Data0      = valid0 ? rdata : '0;
    bus.Data1      = valid1 ? rdata : '0;
  end

endmodule
